fa: RTL and testbench
=====================

FA -- requirements
Module: fa

Interface
- REQ-001: Parameter WIDTH, default 1, SHALL be the operand width in bits (1 = single full-adder bit cell); legal range 1..64.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  qualifies a, b, cin in the current cycle.
- REQ-005: a  input  WIDTH  addend A, unsigned.
- REQ-006: b  input  WIDTH  addend B, unsigned.
- REQ-007: cin  input  1  carry in to bit 0.
- REQ-008: sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- REQ-009: cout  output  1  registered carry out of bit WIDTH-1.
- REQ-010: out_valid  output  1  high for exactly one cycle per accepted input.
- REQ-011: prop  output  WIDTH  registered per-bit propagate, a[i] XOR b[i].
- REQ-012: gen  output  WIDTH  registered per-bit generate, a[i] AND b[i].
- REQ-013: grp_p  output  1  registered group propagate, AND of all prop bits.
- REQ-014: grp_g  output  1  registered group generate, carry out of bit WIDTH-1 with cin forced to 0.

Function
- REQ-015: Bit i SHALL implement full-adder equations: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin; cout = c[WIDTH].
- REQ-016: {cout, sum} SHALL equal a + b + cin exactly as a WIDTH+1-bit unsigned value; no saturation.
- REQ-017: Latency SHALL be 1 cycle: inputs sampled at rising edge N with in_valid=1 appear on all outputs after edge N, with out_valid=1.
- REQ-018: When in_valid=0 at an edge, sum, cout, prop, gen, grp_p, grp_g SHALL hold their previous values and out_valid SHALL be 0.
- REQ-019: Back-to-back in_valid=1 SHALL be accepted every cycle with no bubbles; no backpressure exists.
- REQ-020: Wrap-around: all-ones + all-ones + 1 SHALL give sum = all-ones, cout = 1.
- REQ-021: Outputs SHALL depend only on the sampled registered values; there is no combinational path from inputs to outputs.
- REQ-022: grp_g | (grp_p & cin) SHALL equal cout for every accepted input (lookahead consistency).

Reset
- REQ-023: rst=1 SHALL immediately, without a clock edge, force sum=0, cout=0, prop=0, gen=0, grp_p=0, grp_g=0, out_valid=0.
- REQ-024: While rst=1, inputs SHALL be ignored; an input presented in the cycle rst deasserts SHALL be accepted at the first rising edge with rst=0.
- REQ-025: Reset asserted mid-stream SHALL discard the in-flight result; no out_valid pulse for it.

Verification
- REQ-026: WIDTH=1, all 8 combinations of (a,b,cin), in_valid=1 -> next cycle {cout,sum} = 00,01,01,10,01,10,10,11 in order a,b,cin = 000..111.
- REQ-027: WIDTH=8, a=36, b=129, cin=1 -> sum=166, cout=0, prop=0xA5, gen=0x00, grp_p=0, grp_g=0, out_valid=1 one cycle later.
- REQ-028: WIDTH=8, a=255, b=1, cin=0 -> sum=0, cout=1, grp_p=0, grp_g=1; then a=255, b=0, cin=1 -> sum=0, cout=1, grp_p=1, grp_g=0.
- REQ-029: WIDTH=8, a=255, b=255, cin=1 -> sum=255, cout=1; then in_valid=0 for 3 cycles -> outputs hold, out_valid=0.
- REQ-030: Stream 5 random WIDTH=8 vectors on consecutive cycles -> 5 consecutive out_valid pulses, each {cout,sum} = a+b+cin of the vector one cycle earlier.
- REQ-031: Assert rst asynchronously between edges after a valid input -> all outputs 0 immediately, no out_valid; release rst, apply a=10, b=20, cin=0 -> sum=30, cout=0.

Source files
------------

// File: rtl/fa.sv
// Registered WIDTH-bit ripple-carry adder built from full-adder bit cells.
// Besides the sum and carry, it exposes the per-bit propagate/generate terms
// and the group propagate/generate pair. All outputs come straight from
// registers and update only on accepted (in_valid) cycles.

// Single full-adder bit cell, purely combinational.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co,
    output logic p,
    output logic g
);
    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign co = g | (p & ci);
endmodule

module fa #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    output logic [WIDTH-1:0] prop,
    output logic [WIDTH-1:0] gen,
    output logic             grp_p,
    output logic             grp_g
);
    // c:  ripple carry chain seeded with cin.
    // gc: the same chain seeded with 0. Its top bit is the group generate,
    //     so grp_g | (grp_p & cin) == cout holds by construction.
    logic [WIDTH:0]   c;
    logic [WIDTH:0]   gc;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;

    assign c[0]  = cin;
    assign gc[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s_d[i]),
            .co (c[i+1]),
            .p  (p_d[i]),
            .g  (g_d[i])
        );
        assign gc[i+1] = g_d[i] | (p_d[i] & gc[i]);
    end

    // The result registers load only on accepted inputs and hold otherwise.
    // Reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            cout  <= 1'b0;
            prop  <= '0;
            gen   <= '0;
            grp_p <= 1'b0;
            grp_g <= 1'b0;
        end else if (in_valid) begin
            sum   <= s_d;
            cout  <= c[WIDTH];
            prop  <= p_d;
            gen   <= g_d;
            grp_p <= &p_d;
            grp_g <= gc[WIDTH];
        end
    end

    // Single-stage valid pipe. It pulses for one cycle per accepted input.
    // Reset drops any result that is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_valid <= 1'b0;
        else     out_valid <= in_valid;
    end
endmodule

// File: tb/tb_fa.sv
// Directed bench for fa. Two instances are used:
//   u1 with WIDTH=1, for the truth-table sweep.
//   u8 with WIDTH=8, for the vector, stream and reset cases.
module tb_fa;
    logic       clk;
    logic       rst;
    logic       iv1, a1, b1, cin1;
    logic       s1, co1, ov1, p1, g1, gp1, gg1;
    logic       iv8, cin8;
    logic [7:0] a8, b8;
    logic [7:0] s8, p8, g8;
    logic       co8, ov8, gp8, gg8;

    int ncmp = 0;
    int nfail = 0;

    fa #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .sum(s1), .cout(co1), .out_valid(ov1), .prop(p1), .gen(g1),
        .grp_p(gp1), .grp_g(gg1)
    );

    fa #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .cout(co8), .out_valid(ov8), .prop(p8), .gen(g8),
        .grp_p(gp8), .grp_g(gg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        ncmp++;
        assert (obs === exp_v)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every WIDTH=8 output at once.
    task automatic chk8(input string tag, input logic [7:0] es, input logic ec,
                        input logic ev, input logic [7:0] ep, input logic [7:0] eg,
                        input logic egp, input logic egg);
        chk({tag, ".sum"},   64'(s8),  64'(es));
        chk({tag, ".cout"},  64'(co8), 64'(ec));
        chk({tag, ".ovld"},  64'(ov8), 64'(ev));
        chk({tag, ".prop"},  64'(p8),  64'(ep));
        chk({tag, ".gen"},   64'(g8),  64'(eg));
        chk({tag, ".grp_p"}, 64'(gp8), 64'(egp));
        chk({tag, ".grp_g"}, 64'(gg8), 64'(egg));
    endtask

    initial begin
        // Expected {cout,sum} for a,b,cin = 000 .. 111.
        logic [1:0] tt [8];
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rsum;
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1;
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        iv8 = 0; a8 = 0; b8 = 0; cin8 = 0;

        // Reset state after an edge with rst held high.
        tick();
        chk8("rst0", 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        chk("rst0.u1", 64'({co1, s1, ov1, p1, g1, gp1, gg1}), 64'd0);

        // An input presented while in reset is ignored.
        iv8 = 1; a8 = 8'd36; b8 = 8'd129; cin8 = 1;
        tick();
        chk8("rst_ign", 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

        // Release reset with the input still present. It is accepted at the
        // first edge after release (a=36, b=129, cin=1).
        rst = 1'b0;
        tick();
        chk8("v36_129", 8'd166, 0, 1, 8'hA5, 8'h00, 0, 0);

        // WIDTH=1 truth-table sweep, back to back. u8 is idle and must hold.
        iv8 = 0;
        iv1 = 1;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            tick();
            chk($sformatf("w1_tt%0d", i), 64'({co1, s1}), 64'(tt[i]));
            chk($sformatf("w1_ov%0d", i), 64'(ov1), 64'd1);
        end
        iv1 = 0;
        tick();
        chk("w1_hold", 64'({co1, s1, ov1}), 64'({2'b11, 1'b0}));
        chk8("u8_hold", 8'd166, 0, 0, 8'hA5, 8'h00, 0, 0);

        // 255 + 1 + 0 generates at bit 0 and propagates to the top.
        iv8 = 1; a8 = 8'd255; b8 = 8'd1; cin8 = 0;
        tick();
        chk8("ff_01", 8'h00, 1, 1, 8'hFE, 8'h01, 0, 1);

        // 255 + 0 + 1 carries out through a pure group propagate.
        a8 = 8'd255; b8 = 8'd0; cin8 = 1;
        tick();
        chk8("ff_00_c", 8'h00, 1, 1, 8'hFF, 8'h00, 1, 0);

        // Wrap-around, then 3 idle cycles in which the outputs must hold.
        a8 = 8'd255; b8 = 8'd255; cin8 = 1;
        tick();
        chk8("wrap", 8'hFF, 1, 1, 8'h00, 8'hFF, 0, 1);
        iv8 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8($sformatf("idle%0d", i), 8'hFF, 1, 0, 8'h00, 8'hFF, 0, 1);
        end

        // Five random vectors on consecutive cycles. Each result must appear
        // one edge later with out_valid high.
        iv8 = 1;
        for (int k = 0; k < 5; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            a8 = ra; b8 = rb; cin8 = rc;
            rsum = 9'(ra) + 9'(rb) + 9'(rc);
            tick();
            chk($sformatf("rnd%0d.sum", k), 64'({co8, s8}), 64'(rsum));
            chk($sformatf("rnd%0d.ovld", k), 64'(ov8), 64'd1);
            chk($sformatf("rnd%0d.prop", k), 64'(p8), 64'(ra ^ rb));
            chk($sformatf("rnd%0d.gen", k), 64'(g8), 64'(ra & rb));
            chk($sformatf("rnd%0d.la", k), 64'(gg8 | (gp8 & rc)), 64'(rsum[8]));
        end

        // Assert reset mid-cycle with a new vector waiting. The outputs must
        // clear without an edge, and the waiting vector must never surface.
        a8 = 8'd7; b8 = 8'd9; cin8 = 0;
        #3;
        rst = 1'b1;
        #1;
        chk8("async_rst", 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        tick();
        chk8("rst_hold", 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

        // Release reset and apply 10 + 20 + 0.
        rst = 1'b0;
        a8 = 8'd10; b8 = 8'd20; cin8 = 0;
        tick();
        chk8("post_rst", 8'd30, 0, 1, 8'h1E, 8'h00, 0, 0);
        iv8 = 0;
        tick();
        chk("post_rst.ovld0", 64'(ov8), 64'd0);
        chk("post_rst.hold", 64'(s8), 64'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
